// File: rtl/famicom_pad_reader.sv
// Famicom-style controller poller: drives latch/pulse toward the pad, shifts
// in the active-low serial byte and publishes an active-high button byte.
// Optional build macro FAMICOM_DOUBLE_READ_EN reads the pad twice per poll
// and only publishes when both reads agree.
module famicom_pad_reader #(
   parameter int LATCH_CYCLES = 12,
   parameter int HALF_CYCLES  = 8,
   parameter int POLL_PERIOD  = 1666667
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       enable,
   input  logic       poll_req,
   output logic       famicom_latch,
   output logic       famicom_pulse,
   input  logic       famicom_data,
   output logic [7:0] buttons,
   output logic       buttons_valid,
   output logic       changed,
   output logic       busy,
   output logic       read_error
);

   localparam int PW = $clog2(POLL_PERIOD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_LOW,
      S_HIGH,
      S_GAP,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   poll_cnt;
   logic [15:0]     phase_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            sync_meta;
   logic            sync_data;
   logic            start_poll;
   logic            phase_last;
`ifdef FAMICOM_DOUBLE_READ_EN
   logic            second_pass;
   logic [7:0]      first_read;
`endif

   // Two-flop synchroniser for the pad data line; idles high like an unpressed pad
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync_meta <= 1'b1;
         sync_data <= 1'b1;
      end else begin
         sync_meta <= famicom_data;
         sync_data <= sync_meta;
      end
   end

   // Poll start decision, end-of-phase detection and next-state selection
   always_comb begin
      state_next = state;
      start_poll = 1'b0;
      phase_last = 1'b0;
      if (state == S_IDLE && enable &&
          (poll_cnt == PW'(POLL_PERIOD - 1) || poll_req))
         start_poll = 1'b1;
      case (state)
         S_LATCH:      phase_last = (phase_cnt == 16'(LATCH_CYCLES - 1));
         S_LOW, S_HIGH: phase_last = (phase_cnt == 16'(HALF_CYCLES - 1));
         S_GAP:        phase_last = (phase_cnt == 16'(2 * HALF_CYCLES - 1));
         default:      phase_last = 1'b0;
      endcase
      case (state)
         S_IDLE:  if (start_poll) state_next = S_LATCH;
         S_LATCH: if (phase_last) state_next = S_LOW;
         S_LOW: begin
            if (phase_last) begin
               if (bit_idx == 3'd7) begin
`ifdef FAMICOM_DOUBLE_READ_EN
                  state_next = second_pass ? S_DONE : S_GAP;
`else
                  state_next = S_DONE;
`endif
               end else begin
                  state_next = S_HIGH;
               end
            end
         end
         S_HIGH:  if (phase_last) state_next = S_LOW;
         S_GAP:   if (phase_last) state_next = S_LATCH;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register, phase/poll counters, bit capture and registered outputs
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state         <= S_IDLE;
         poll_cnt      <= '0;
         phase_cnt     <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         famicom_latch <= 1'b0;
         famicom_pulse <= 1'b0;
         buttons       <= '0;
         buttons_valid <= 1'b0;
         changed       <= 1'b0;
         busy          <= 1'b0;
         read_error    <= 1'b0;
`ifdef FAMICOM_DOUBLE_READ_EN
         second_pass   <= 1'b0;
         first_read    <= '0;
`endif
      end else begin
         state         <= state_next;
         famicom_latch <= (state_next == S_LATCH);
         famicom_pulse <= (state_next == S_HIGH);
         busy          <= (state_next != S_IDLE);
         buttons_valid <= 1'b0;
         changed       <= 1'b0;
         read_error    <= 1'b0;

         if (state_next != state || state == S_IDLE)
            phase_cnt <= '0;
         else
            phase_cnt <= phase_cnt + 16'd1;

         if (start_poll || !enable)
            poll_cnt <= '0;
         else if (state == S_IDLE)
            poll_cnt <= (poll_cnt == PW'(POLL_PERIOD - 1)) ? '0 : poll_cnt + 1'b1;

         if (state == S_LATCH && phase_last)
            bit_idx <= '0;
         if (state == S_LOW && phase_last)
            shift[bit_idx] <= sync_data;
         if (state == S_HIGH && phase_last)
            bit_idx <= bit_idx + 3'd1;

`ifdef FAMICOM_DOUBLE_READ_EN
         if (state == S_IDLE)
            second_pass <= 1'b0;
         if (state == S_GAP) begin
            first_read <= shift;
            if (phase_last)
               second_pass <= 1'b1;
         end
         if (state == S_DONE) begin
            if (shift == first_read) begin
               buttons       <= ~shift;
               buttons_valid <= 1'b1;
               changed       <= (~shift != buttons);
            end else begin
               read_error    <= 1'b1;
            end
         end
`else
         if (state == S_DONE) begin
            buttons       <= ~shift;
            buttons_valid <= 1'b1;
            changed       <= (~shift != buttons);
         end
`endif
      end
   end

endmodule

// File: tb/tb_famicom_pad_reader.sv
// Scoreboard bench for famicom_pad_reader with a behavioural model of the
// pad shift register. Builds with or without FAMICOM_DOUBLE_READ_EN.
module tb_famicom_pad_reader;

   localparam int LATCH_CYCLES = 12;
   localparam int HALF_CYCLES  = 8;
   localparam int POLL_PERIOD  = 200;
`ifdef FAMICOM_DOUBLE_READ_EN
   localparam int LATENCY = 281;
   localparam int PULSES  = 14;
`else
   localparam int LATENCY = 133;
   localparam int PULSES  = 7;
`endif

   typedef struct {
      bit         is_err;
      logic [7:0] btn;
      bit         chg;
   } exp_t;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       poll_req = 1'b0;
   logic       famicom_latch;
   logic       famicom_pulse;
   logic       famicom_data;
   logic [7:0] buttons;
   logic       buttons_valid;
   logic       changed;
   logic       busy;
   logic       read_error;

   logic [7:0] pad_byte = 8'hFF;
   logic [7:0] pad_sr = 8'hFF;
   logic       pad_pulse_prev = 1'b0;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sb[$];

   logic mon_latch_q = 1'b0;
   logic mon_busy_q = 1'b0;
   logic mon_pulse_q = 1'b0;
   bit   mon_one_shot = 1'b0;
   bit   mon_bad_len = 1'b0;
   int   mon_start = 0;
   int   mon_rises = 0;
   int   mon_hi_len = 0;
   exp_t mon_e;

   famicom_pad_reader #(
      .LATCH_CYCLES(LATCH_CYCLES),
      .HALF_CYCLES (HALF_CYCLES),
      .POLL_PERIOD (POLL_PERIOD)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .enable       (enable),
      .poll_req     (poll_req),
      .famicom_latch(famicom_latch),
      .famicom_pulse(famicom_pulse),
      .famicom_data (famicom_data),
      .buttons      (buttons),
      .buttons_valid(buttons_valid),
      .changed      (changed),
      .busy         (busy),
      .read_error   (read_error)
   );

   always #5 clk_sys = ~clk_sys;

   assign famicom_data = pad_sr[0];

   // Free-running edge counter used for latency measurement
   initial forever begin
      @(posedge clk_sys);
      cyc++;
   end

   // Pad shift register: loads while latch is high, shifts in 0 on pulse rise
   initial forever begin
      @(negedge clk_sys);
      if (famicom_latch)
         pad_sr = pad_byte;
      else if (famicom_pulse && !pad_pulse_prev)
         pad_sr = {1'b0, pad_sr[7:1]};
      pad_pulse_prev = famicom_pulse;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Present a pad byte and queue the hand-computed response of the next poll
   task automatic applyStimulus(input logic [7:0] pad, input bit is_err,
                                input logic [7:0] exp_btn, input bit exp_chg);
      exp_t e;
      pad_byte = pad;
      e.is_err = is_err;
      e.btn    = exp_btn;
      e.chg    = exp_chg;
      sb.push_back(e);
   endtask

   task automatic pulseReq();
      poll_req = 1'b1;
      @(negedge clk_sys);
      poll_req = 1'b0;
   endtask

   task automatic waitOutput(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (!(buttons_valid || read_error) && n < budget);
      if (!(buttons_valid || read_error))
         checkOutput("output_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: tracks poll start and pulse shape, pops the scoreboard on each result
   initial forever begin
      @(negedge clk_sys);
      if (mon_one_shot) begin
         checkOutput("strobe_one_cycle", {29'd0, buttons_valid, changed, read_error}, 32'd0);
         mon_one_shot = 1'b0;
      end
      if (famicom_latch && !mon_latch_q && !mon_busy_q) begin
         mon_start   = cyc;
         mon_rises   = 0;
         mon_bad_len = 1'b0;
      end
      if (famicom_pulse && !mon_pulse_q) begin
         mon_rises++;
         mon_hi_len = 1;
      end else if (famicom_pulse) begin
         mon_hi_len++;
      end
      if (!famicom_pulse && mon_pulse_q && mon_hi_len != HALF_CYCLES)
         mon_bad_len = 1'b1;
      if (buttons_valid || read_error) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_output", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("result_kind", {30'd0, buttons_valid, read_error},
                        {30'd0, ~mon_e.is_err, mon_e.is_err});
            checkOutput("buttons", {24'd0, buttons}, {24'd0, mon_e.btn});
            checkOutput("changed", {31'd0, changed}, {31'd0, mon_e.chg});
            checkOutput("latency", cyc - mon_start, LATENCY);
            checkOutput("pulse_count", mon_rises, PULSES);
            checkOutput("pulse_high_len_ok", {31'd0, mon_bad_len}, 32'd0);
         end
         mon_one_shot = 1'b1;
      end
      mon_latch_q = famicom_latch;
      mon_busy_q  = busy;
      mon_pulse_q = famicom_pulse;
   end

   // Directed test sequence
   initial begin
      int k;
      int seen;
      logic prevp;

      $display("[TB] start, expected poll latency %0d", LATENCY);
      reset  = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk_sys);
      checkOutput("reset_latch", {31'd0, famicom_latch}, 32'd0);
      checkOutput("reset_pulse", {31'd0, famicom_pulse}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_buttons", {24'd0, buttons}, 32'd0);
      checkOutput("reset_strobes", {29'd0, buttons_valid, changed, read_error}, 32'd0);

      // Automatic poll after release; pad 1111_1110 -> buttons 01
      applyStimulus(8'hFE, 1'b0, 8'h01, 1'b1);
      reset = 1'b0;
      k = 0;
      do begin
         @(negedge clk_sys);
         k++;
      end while (!famicom_latch && k < 400);
      checkOutput("first_auto_poll_delay", k, POLL_PERIOD);
      seen = 0;
      while (famicom_latch && seen < 100) begin
         seen++;
         @(negedge clk_sys);
      end
      checkOutput("latch_width", seen, LATCH_CYCLES);
      waitOutput(1000);

      // Same byte again, then a new byte
      applyStimulus(8'hFE, 1'b0, 8'h01, 1'b0);
      waitOutput(1000);
      applyStimulus(8'h7F, 1'b0, 8'h80, 1'b1);
      waitOutput(1000);

      // Requested poll from idle, then a dropped request while busy
      @(negedge clk_sys);
      applyStimulus(8'h7F, 1'b0, 8'h80, 1'b0);
      pulseReq();
      checkOutput("req_latch_next", {31'd0, famicom_latch}, 32'd1);
      repeat (20) @(negedge clk_sys);
      pulseReq();
      waitOutput(1000);
      seen = 0;
      repeat (100) begin
         @(negedge clk_sys);
         if (famicom_latch) seen++;
      end
      checkOutput("no_extra_poll", seen, 0);

      // Disabled: neither requests nor the timer start a poll
      enable = 1'b0;
      pulseReq();
      seen = 0;
      repeat (3 * POLL_PERIOD) begin
         @(negedge clk_sys);
         if (famicom_latch) seen++;
      end
      checkOutput("disabled_no_poll", seen, 0);

      // Reset during the 4th pulse high phase
      enable = 1'b1;
      pulseReq();
      k = 0;
      seen = 0;
      prevp = 1'b0;
      while (seen < 4 && k < 1000) begin
         @(negedge clk_sys);
         k++;
         if (famicom_pulse && !prevp) seen++;
         prevp = famicom_pulse;
      end
      checkOutput("fourth_pulse_seen", seen, 4);
      repeat (2) @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      checkOutput("midreset_latch", {31'd0, famicom_latch}, 32'd0);
      checkOutput("midreset_pulse", {31'd0, famicom_pulse}, 32'd0);
      checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midreset_buttons", {24'd0, buttons}, 32'd0);
      reset = 1'b0;
      applyStimulus(8'hA5, 1'b0, 8'h5A, 1'b1);
      pulseReq();
      waitOutput(1000);

`ifdef FAMICOM_DOUBLE_READ_EN
      // Byte changes between the two reads: error, buttons hold 5A
      applyStimulus(8'h0F, 1'b1, 8'h5A, 1'b0);
      pulseReq();
      k = 0;
      while (famicom_latch && k < 400) begin
         @(negedge clk_sys);
         k++;
      end
      while (!famicom_latch && k < 400) begin
         @(negedge clk_sys);
         k++;
      end
      checkOutput("second_latch_seen", {31'd0, famicom_latch}, 32'd1);
      pad_byte = 8'hF0;
      waitOutput(1000);

      // Stable byte publishes normally
      applyStimulus(8'h0F, 1'b0, 8'hF0, 1'b1);
      pulseReq();
      waitOutput(1000);
`endif

      repeat (4) @(negedge clk_sys);
      checkOutput("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
